// File: rtl/icache_pkg.sv
// Shared instruction-cache definitions: default geometry, refill state
// encoding and the address split used by the array, hit logic and refill.
package icache_pkg;

  localparam int OFFSET_WIDTH = 2;
  localparam int LINE_WIDTH   = 6;
  localparam int TAG_WIDTH    = 32 - OFFSET_WIDTH - LINE_WIDTH - 2;
  localparam int BLOCK_SIZE   = 1 << OFFSET_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    WRITE = 2'd3
  } refill_state_e;

  // Line index of a byte address at the default geometry.
  function automatic logic [LINE_WIDTH-1:0] addr_index(input logic [31:0] addr);
    return addr[LINE_WIDTH+OFFSET_WIDTH+1 : OFFSET_WIDTH+2];
  endfunction

  // Tag of a byte address at the default geometry.
  function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [31:0] addr);
    return addr[31 : 32-TAG_WIDTH];
  endfunction

endpackage

// File: rtl/icache_refill_controller.sv
// Instruction-cache refill engine: fetches one block word by word over a
// valid/ready memory port, then writes it into the cache array in one cycle.
//
// state | meaning
// IDLE  | waiting for a miss; miss_ready high
// REQ   | presenting the read request for word count
// RESP  | one request outstanding, waiting for its data
// WRITE | one-cycle write strobe to the cache array
module icache_refill_controller
  import icache_pkg::*;
#(
  parameter int offset_width = OFFSET_WIDTH,
  parameter int line_width   = LINE_WIDTH,
  parameter int tag_width    = 32 - offset_width - line_width - 2,
  parameter int block_size   = 1 << offset_width
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        miss_valid,
  output logic                        miss_ready,
  input  logic [31:0]                 miss_address,
  input  logic                        invalidate_all,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [31:0]                 mem_req_address,
  input  logic                        mem_resp_valid,
  output logic                        mem_resp_ready,
  input  logic [31:0]                 mem_resp_data,
  output logic                        write_in,
  output logic [line_width-1:0]       write_line_index,
  output logic [tag_width-1:0]        write_tag,
  output logic [32*block_size-1:0]    write_block
);

  refill_state_e                 state_q, state_d;
  logic [offset_width-1:0]       count_q, count_d;
  logic                          abort_q, abort_d;
  logic [tag_width-1:0]          tag_q, tag_d;
  logic [line_width-1:0]         line_q, line_d;
  logic [32*block_size-1:0]      block_q, block_d;

  // State, counters and the assembled block; synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      abort_q <= 1'b0;
      tag_q   <= '0;
      line_q  <= '0;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      abort_q <= abort_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
      block_q <= block_d;
    end
  end

  // Next-state and handshake decode; an abort lets the outstanding response
  // drain before returning to IDLE so the memory side is never left hanging.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    abort_d        = abort_q;
    tag_d          = tag_q;
    line_d         = line_q;
    block_d        = block_q;
    miss_ready     = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    write_in       = 1'b0;
    case (state_q)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          tag_d   = miss_address[31 : 32-tag_width];
          line_d  = miss_address[line_width+offset_width+1 : offset_width+2];
          count_d = '0;
          abort_d = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (invalidate_all) abort_d = 1'b1;
        if (mem_req_ready) state_d = RESP;
      end
      RESP: begin
        mem_resp_ready = 1'b1;
        if (invalidate_all) abort_d = 1'b1;
        if (mem_resp_valid) begin
          block_d[32*int'(count_q) +: 32] = mem_resp_data;
          if (abort_q || invalidate_all) begin
            state_d = IDLE;
          end else if (&count_q) begin
            state_d = WRITE;
          end else begin
            count_d = count_q + 1'b1;
            state_d = REQ;
          end
        end
      end
      WRITE: begin
        write_in = !abort_q && !invalidate_all;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_address  = {tag_q, line_q, count_q, 2'b00};
  assign write_line_index = line_q;
  assign write_tag        = tag_q;
  assign write_block      = block_q;

endmodule

// File: tb/tb_icache_refill_controller.sv
// Scoreboard bench for icache_refill_controller: stimulus pushes expected
// request addresses and cache writes; a negedge monitor pops and compares.
module tb_icache_refill_controller;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         miss_valid = 1'b0;
  logic         miss_ready;
  logic [31:0]  miss_address = '0;
  logic         invalidate_all = 1'b0;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_address;
  logic         mem_resp_valid;
  logic         mem_resp_ready;
  logic [31:0]  mem_resp_data;
  logic         write_in;
  logic [5:0]   write_line_index;
  logic [21:0]  write_tag;
  logic [127:0] write_block;

  icache_refill_controller dut (
    .clock(clock), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_address(miss_address),
    .invalidate_all(invalidate_all),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_address(mem_req_address),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_data(mem_resp_data),
    .write_in(write_in), .write_line_index(write_line_index),
    .write_tag(write_tag), .write_block(write_block)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input logic [127:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected no event", name, act);
  endtask

  task automatic to_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait expired before condition reached", name);
  endtask

  typedef struct {
    logic [5:0]   line;
    logic [21:0]  tag;
    logic [127:0] block;
  } wr_t;

  logic [31:0] exp_addr_q[$];
  wr_t         exp_wr_q[$];
  logic [31:0] mem_data_q[$];

  // memory model: request stall and response delay knobs set by stimulus
  int          req_stall = 0;
  int          resp_delay = 1;
  int          wait_cnt = 0;
  int          dcnt = 0;
  bit          pend = 0;
  logic [31:0] pend_data = '0;
  bit          s_rst, s_rq, s_rs, s_seen;

  initial begin : memory_model
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(negedge clock);
      s_rst  = reset;
      s_rq   = mem_req_valid && mem_req_ready;
      s_rs   = mem_resp_valid && mem_resp_ready;
      s_seen = mem_req_valid;
      @(posedge clock);
      #1;
      if (!s_rst) begin
        pend = 0;
        mem_resp_valid = 1'b0;
        wait_cnt = 0;
        mem_req_ready = (req_stall == 0);
      end else begin
        if (s_rs) begin
          mem_resp_valid = 1'b0;
          pend = 0;
        end
        if (s_rq) begin
          pend = 1;
          dcnt = resp_delay;
          pend_data = (mem_data_q.size() > 0) ? mem_data_q.pop_front() : 32'hDEAD_BEEF;
          wait_cnt = 0;
        end else if (s_seen) begin
          wait_cnt++;
        end
        mem_req_ready = (wait_cnt >= req_stall);
        if (pend && !mem_resp_valid) begin
          dcnt--;
          if (dcnt <= 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = pend_data;
          end
        end
      end
    end
  end

  // monitor state
  int          req_fires = 0, resp_fires = 0, writes = 0;
  int          fire_cyc = 0, write_cyc = 0;
  int          stable_viol = 0, busy_viol = 0;
  bit          watch_busy = 0;
  bit          busy = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_addr = '0;
  wr_t         mon_e;

  initial begin : monitor
    forever begin
      @(negedge clock);
      if (reset) begin
        if (write_in) begin
          writes++;
          write_cyc = cyc;
          busy = 0;
          if (exp_wr_q.size() == 0) fail_evt("unexpected_write", 128'(write_line_index));
          else begin
            mon_e = exp_wr_q.pop_front();
            chk("write_line", 128'(write_line_index), 128'(mon_e.line));
            chk("write_tag", 128'(write_tag), 128'(mon_e.tag));
            chk("write_block", write_block, mon_e.block);
          end
        end
        if (busy && miss_ready) begin
          if (watch_busy) busy_viol++;
          busy = 0;
        end
        if (miss_valid && miss_ready) begin
          fire_cyc = cyc;
          busy = 1;
        end
        if (prev_stall && (!mem_req_valid || mem_req_address !== prev_addr)) stable_viol++;
        prev_stall = mem_req_valid && !mem_req_ready;
        prev_addr  = mem_req_address;
        if (mem_req_valid && mem_req_ready) begin
          req_fires++;
          if (exp_addr_q.size() == 0) fail_evt("unexpected_req", 128'(mem_req_address));
          else chk("req_addr", 128'(mem_req_address), 128'(exp_addr_q.pop_front()));
        end
        if (mem_resp_valid && mem_resp_ready) resp_fires++;
      end else begin
        prev_stall = 0;
        busy = 0;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
    #1;
  endtask

  // queue the expected requests, memory data and (optionally) the final write
  task automatic push_refill(input logic [31:0] addr, input logic [31:0] base,
                             input logic [5:0] line, input logic [21:0] tag,
                             input int nwords, input bit with_write);
    logic [127:0] blk;
    logic [31:0]  blk_addr;
    blk = '0;
    blk_addr = addr & 32'hFFFF_FFF0;
    for (int j = 0; j < nwords; j++) begin
      exp_addr_q.push_back(blk_addr + 32'(4 * j));
      mem_data_q.push_back(base + 32'(j));
      blk[32*j +: 32] = base + 32'(j);
    end
    for (int j = nwords; j < 4; j++) begin
      blk[32*j +: 32] = base + 32'(j);
      mem_data_q.push_back(base + 32'(j));
    end
    if (nwords < 4) for (int j = nwords; j < 4; j++) void'(mem_data_q.pop_back());
    if (with_write) exp_wr_q.push_back('{line, tag, blk});
  endtask

  task automatic do_miss(input logic [31:0] addr);
    bit ok;
    step();
    miss_valid = 1'b1;
    miss_address = addr;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      sample();
      if (miss_ready) begin ok = 1; break; end
    end
    if (!ok) to_fail("miss_accept");
    step();
    miss_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n, input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      if (writes >= n) begin ok = 1; break; end
      sample();
    end
    if (!ok) to_fail(name);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int  rq0, rf0, wr0, wcyc1;
  bit  ok;

  initial begin : stimulus
    repeat (3) step();
    sample();
    chk("rst_miss_ready_low", 128'(miss_ready), 128'(1'b1));
    step();
    reset = 1'b1;
    sample();
    chk("rst_miss_ready", 128'(miss_ready), 128'(1'b1));
    chk("rst_req_valid", 128'(mem_req_valid), 128'(1'b0));
    chk("rst_resp_ready", 128'(mem_resp_ready), 128'(1'b0));
    chk("rst_write_in", 128'(write_in), 128'(1'b0));
    chk("rst_write_block", write_block, 128'(0));
    chk("rst_write_tag", 128'(write_tag), 128'(0));
    chk("rst_write_line", 128'(write_line_index), 128'(0));

    // basic refill, 1-cycle memory
    push_refill(32'h0000_1234, 32'hA0, 6'h23, 22'h4, 4, 1);
    do_miss(32'h0000_1234);
    wait_writes(1, "basic_write");
    chk("basic_latency", 128'(write_cyc - fire_cyc), 128'(9));
    sample();
    chk("basic_ready_after", 128'(miss_ready), 128'(1'b1));
    chk("basic_queues", 128'(exp_addr_q.size() + exp_wr_q.size()), 128'(0));

    // backpressure: 3 stalled cycles per request, 5-cycle responses
    req_stall = 3;
    resp_delay = 5;
    watch_busy = 1;
    stable_viol = 0;
    busy_viol = 0;
    rq0 = req_fires;
    wr0 = writes;
    step();
    push_refill(32'h0000_ABC8, 32'hB0, 6'h3C, 22'h2A, 4, 1);
    do_miss(32'h0000_ABC8);
    wait_writes(wr0 + 1, "bp_write");
    sample();
    chk("bp_req_count", 128'(req_fires - rq0), 128'(4));
    chk("bp_write_count", 128'(writes - wr0), 128'(1));
    chk("bp_addr_stable", 128'(stable_viol), 128'(0));
    chk("bp_miss_ready_busy", 128'(busy_viol), 128'(0));
    watch_busy = 0;
    req_stall = 0;
    resp_delay = 1;

    // flush while waiting for word 2
    resp_delay = 3;
    step();
    step();
    rq0 = req_fires;
    rf0 = resp_fires;
    wr0 = writes;
    push_refill(32'h0000_2000, 32'hC0, 6'h00, 22'h8, 3, 0);
    do_miss(32'h0000_2000);
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      sample();
      if (req_fires == rq0 + 3 && mem_resp_ready && !mem_resp_valid) begin ok = 1; break; end
    end
    if (!ok) to_fail("flush_wait_word2");
    step();
    invalidate_all = 1'b1;
    step();
    invalidate_all = 1'b0;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      sample();
      if (resp_fires == rf0 + 3) begin ok = 1; break; end
    end
    if (!ok) to_fail("flush_word2_resp");
    sample();
    chk("flush_miss_ready", 128'(miss_ready), 128'(1'b1));
    chk("flush_req_valid", 128'(mem_req_valid), 128'(1'b0));
    repeat (5) sample();
    chk("flush_resp_count", 128'(resp_fires - rf0), 128'(3));
    chk("flush_req_count", 128'(req_fires - rq0), 128'(3));
    chk("flush_no_write", 128'(writes - wr0), 128'(0));
    resp_delay = 1;

    // flush coincident with WRITE
    rf0 = resp_fires;
    wr0 = writes;
    push_refill(32'h0000_3340, 32'hD0, 6'h34, 22'hC, 4, 0);
    do_miss(32'h0000_3340);
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      sample();
      if (resp_fires == rf0 + 4 && mem_resp_valid && mem_resp_ready) begin ok = 1; break; end
    end
    if (!ok) to_fail("wflush_wait_last");
    step();
    invalidate_all = 1'b1;
    sample();
    chk("wflush_write_in", 128'(write_in), 128'(1'b0));
    chk("wflush_busy", 128'(miss_ready), 128'(1'b0));
    step();
    invalidate_all = 1'b0;
    sample();
    chk("wflush_idle", 128'(miss_ready), 128'(1'b1));
    chk("wflush_no_write", 128'(writes - wr0), 128'(0));

    // back-to-back misses
    wr0 = writes;
    push_refill(32'h0000_1234, 32'hE0, 6'h23, 22'h4, 4, 1);
    push_refill(32'hFFFF_FFF0, 32'hF0, 6'h3F, 22'h3F_FFFF, 4, 1);
    step();
    miss_valid = 1'b1;
    miss_address = 32'h0000_1234;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      sample();
      if (miss_ready) begin ok = 1; break; end
    end
    if (!ok) to_fail("b2b_first_accept");
    step();
    miss_address = 32'hFFFF_FFF0;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      sample();
      if (miss_ready) begin ok = 1; break; end
    end
    if (!ok) to_fail("b2b_second_accept");
    wcyc1 = write_cyc;
    step();
    miss_valid = 1'b0;
    chk("b2b_accept_cycle", 128'(fire_cyc - wcyc1), 128'(1));
    wait_writes(wr0 + 2, "b2b_writes");
    sample();
    chk("b2b_queues", 128'(exp_addr_q.size() + exp_wr_q.size()), 128'(0));

    // reset after word 1, then a clean refill
    rf0 = resp_fires;
    push_refill(32'h0000_5670, 32'h10, 6'h27, 22'h15, 4, 1);
    do_miss(32'h0000_5670);
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      sample();
      if (resp_fires == rf0 + 2) begin ok = 1; break; end
    end
    if (!ok) to_fail("rst_mid_wait");
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    exp_addr_q.delete();
    exp_wr_q.delete();
    mem_data_q.delete();
    sample();
    chk("rmid_req_valid", 128'(mem_req_valid), 128'(1'b0));
    chk("rmid_write_in", 128'(write_in), 128'(1'b0));
    chk("rmid_miss_ready", 128'(miss_ready), 128'(1'b1));
    chk("rmid_write_block", write_block, 128'(0));
    chk("rmid_write_tag", 128'(write_tag), 128'(0));
    chk("rmid_write_line", 128'(write_line_index), 128'(0));
    wr0 = writes;
    push_refill(32'h0000_5670, 32'h20, 6'h27, 22'h15, 4, 1);
    do_miss(32'h0000_5670);
    wait_writes(wr0 + 1, "rmid_refill_write");
    sample();
    chk("rmid_queues", 128'(exp_addr_q.size() + exp_wr_q.size()), 128'(0));

    repeat (3) sample();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
